// File: rtl/fir_chan_scheduler_if.sv
// Channel-side and FIR-IP-side signal bundle for fir_chan_scheduler.
// The scheduler connects through the slave modport and its environment through master.
interface fir_chan_scheduler_if #(
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic        [NCH*16-1:0] ch_data;
  logic        [NCH-1:0]    ch_valid;
  logic        [NCH-1:0]    ch_ready;
  logic signed [15:0]       ast_sink_data;
  logic                     ast_sink_valid;
  logic signed [31:0]       ast_source_data;
  logic                     ast_source_valid;
  logic signed [31:0]       out_data;
  logic        [CW-1:0]     out_chan;
  logic                     out_valid;

  modport slave (
    input  ch_data, ch_valid, ast_source_data, ast_source_valid,
    output ch_ready, ast_sink_data, ast_sink_valid, out_data, out_chan, out_valid
  );

  modport master (
    output ch_data, ch_valid, ast_source_data, ast_source_valid,
    input  ch_ready, ast_sink_data, ast_sink_valid, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/fir_chan_scheduler.sv
// Time-multiplexes NCH sample channels onto one FIR IP: round-robin issue,
// in-order tag FIFO to route each FIR result back to its source channel.
module fir_chan_scheduler #(
  parameter int NCH   = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  fir_chan_scheduler_if.slave    bus,
  output logic                   busy,
  output logic                   err_orphan
);
  localparam int CW = $clog2(NCH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} mode_t;

  mode_t              mode;
  logic [CW-1:0]      rr_ptr;
  logic [CW-1:0]      grant;
  logic [CW-1:0]      idx;
  logic               found;
  logic               grant_ok;
  logic               xfer;
  logic               pop;
  logic [AW:0]        count;
  logic [AW:0]        count_nxt;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      tag_mem [DEPTH];
  logic signed [15:0] sample;

  logic signed [15:0] sink_data_p1;
  logic               sink_vld_p1;
  logic signed [31:0] out_data_p1;
  logic [CW-1:0]      out_chan_p1;
  logic               out_vld_p1;
  logic               busy_p1;
  logic               err_p1;

  // Mode is a pure function of enable and occupancy; only RUN may grant.
  always_comb begin
    if (enable)            mode = RUN;
    else if (count != '0)  mode = DRAIN;
    else                   mode = IDLE;
  end

  // Full is judged on the pre-edge count, so a pop in the same cycle does not reopen grants.
  assign grant_ok = !reset && (mode == RUN) && (count < FULL);

  always_comb begin
    grant = rr_ptr;
    idx   = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = rr_ptr + CW'(i);
      if (!found && bus.ch_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign xfer   = grant_ok && found;
  assign pop    = bus.ast_source_valid && (count != '0);
  assign sample = bus.ch_data[{grant, 4'b0000} +: 16];

  always_comb begin
    bus.ch_ready = '0;
    if (xfer) bus.ch_ready[grant] = 1'b1;
  end

  always_comb begin
    count_nxt = count;
    if (xfer && !pop)      count_nxt = count + (AW+1)'(1);
    else if (pop && !xfer) count_nxt = count - (AW+1)'(1);
  end

  // Tag storage carries no control meaning, so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer) tag_mem[wr_ptr] <= grant;
  end

  // Stage p1: issue to FIR sink and route returning results.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sink_vld_p1  <= 1'b0;
      sink_data_p1 <= '0;
      out_vld_p1   <= 1'b0;
      out_data_p1  <= '0;
      out_chan_p1  <= '0;
      busy_p1      <= 1'b0;
      err_p1       <= 1'b0;
    end else begin
      sink_vld_p1 <= xfer;
      out_vld_p1  <= pop;
      count       <= count_nxt;
      busy_p1     <= (count_nxt != '0);
      if (xfer) begin
        sink_data_p1 <= sample;
        wr_ptr       <= wr_ptr + AW'(1);
        rr_ptr       <= grant + CW'(1);
      end
      if (pop) begin
        out_data_p1 <= bus.ast_source_data;
        out_chan_p1 <= tag_mem[rd_ptr];
        rd_ptr      <= rd_ptr + AW'(1);
      end
      if (bus.ast_source_valid && (count == '0)) err_p1 <= 1'b1;
    end
  end

  assign bus.ast_sink_data  = sink_data_p1;
  assign bus.ast_sink_valid = sink_vld_p1;
  assign bus.out_data       = out_data_p1;
  assign bus.out_chan       = out_chan_p1;
  assign bus.out_valid      = out_vld_p1;
  assign busy               = busy_p1;
  assign err_orphan         = err_p1;
endmodule

// File: tb/tb_fir_chan_scheduler.sv
// Directed bench for fir_chan_scheduler with a reference model and
// queue-based scoreboards for sink issue and result routing.
module tb_fir_chan_scheduler;
  localparam int NCH   = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic busy;
  logic err_orphan;

  fir_chan_scheduler_if #(.NCH(NCH)) bus ();

  fir_chan_scheduler #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 chan;
    logic signed [31:0] data;
  } res_t;

  int checks = 0;
  int errors = 0;

  int                 m_rr;
  int                 tag_q  [$];
  logic signed [15:0] sink_q [$];
  res_t               out_q  [$];
  bit                 exp_sv;
  bit                 exp_ov;
  bit                 exp_err;
  logic signed [15:0] last_sink;
  logic signed [31:0] last_out;
  int                 last_chan;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(bit en, logic [NCH-1:0] v, bit sv, logic signed [31:0] sd);
    enable               = en;
    bus.ch_valid         = v;
    bus.ast_source_valid = sv;
    bus.ast_source_data  = sd;
    for (int k = 0; k < NCH; k++) bus.ch_data[16*k +: 16] = 16'($urandom);
  endtask

  // One clock: check combinational grant, advance the model, check registered outputs.
  task automatic step();
    int             g;
    int             t;
    logic [NCH-1:0] exp_ready;
    res_t           r;
    #1;
    g         = -1;
    exp_ready = '0;
    if (!reset && enable && tag_q.size() < DEPTH) begin
      for (int i = 0; i < NCH; i++) begin
        if (g < 0 && bus.ch_valid[(m_rr + i) % NCH]) g = (m_rr + i) % NCH;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("ch_ready", 64'(bus.ch_ready), 64'(exp_ready));

    if (reset) begin
      tag_q.delete();
      sink_q.delete();
      out_q.delete();
      m_rr      = 0;
      exp_sv    = 1'b0;
      exp_ov    = 1'b0;
      exp_err   = 1'b0;
      last_sink = '0;
      last_out  = '0;
      last_chan = 0;
    end else begin
      exp_ov = 1'b0;
      if (bus.ast_source_valid) begin
        if (tag_q.size() > 0) begin
          t      = tag_q.pop_front();
          r.chan = t;
          r.data = bus.ast_source_data;
          out_q.push_back(r);
          exp_ov = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
      exp_sv = (g >= 0);
      if (g >= 0) begin
        tag_q.push_back(g);
        sink_q.push_back(bus.ch_data[16*g +: 16]);
        m_rr = (g + 1) % NCH;
      end
    end

    @(posedge clk);
    #1;
    check("sink_valid", 64'(bus.ast_sink_valid), 64'(exp_sv));
    if (exp_sv && sink_q.size() > 0) last_sink = sink_q.pop_front();
    check("sink_data", 64'(bus.ast_sink_data), 64'(last_sink));
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov && out_q.size() > 0) begin
      r         = out_q.pop_front();
      last_out  = r.data;
      last_chan = r.chan;
    end
    check("out_data", 64'(bus.out_data), 64'(last_out));
    check("out_chan", 64'(bus.out_chan), 64'(last_chan));
    check("busy", 64'(busy), 64'(tag_q.size() != 0));
    check("err_orphan", 64'(err_orphan), 64'(exp_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(1'b1, 4'hF, 1'b0, 32'sd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, '0, 1'b0, 32'sd0);
    step();
    step();
    reset = 1'b0;

    // Single channel issue and echo.
    drv(1'b1, 4'b0001, 1'b0, 32'sd0);
    bus.ch_data[15:0] = 16'sd8192;
    step();
    check("single_sink_data", 64'(bus.ast_sink_data), 64'(16'sd8192));
    drv(1'b1, 4'b0000, 1'b1, 32'h0001_0000);
    step();
    check("single_out_chan", 64'(bus.out_chan), 64'd0);
    check("single_out_data", 64'(bus.out_data), 64'(32'h0001_0000));

    // All channels valid, round-robin from 0 with concurrent returns.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 4'hF, (i >= 1), 32'($urandom));
      step();
    end
    drv(1'b1, 4'h0, 1'b1, 32'($urandom));
    step();

    // Fill the tag FIFO, hold at full, then release one slot.
    for (int i = 0; i < DEPTH; i++) begin
      drv(1'b1, 4'($urandom_range(1, 15)), 1'b0, 32'sd0);
      step();
    end
    check("full_busy", 64'(busy), 64'd1);
    drv(1'b1, 4'hF, 1'b0, 32'sd0);
    step();
    drv(1'b1, 4'hF, 1'b1, 32'sh1234);
    step();
    drv(1'b1, 4'hF, 1'b0, 32'sd0);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drv(1'b0, 4'hF, 1'b1, 32'($urandom));
      step();
    end

    // Orphan result after reset.
    do_reset();
    drv(1'b1, 4'h0, 1'b1, -32'sd4096);
    step();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 4'h0, 1'b0, 32'sd0);
      step();
    end
    check("orphan_sticky", 64'(err_orphan), 64'd1);

    // Drain with enable low.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 4'hF, 1'b0, 32'sd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 4'hF, 1'b1, 32'($urandom));
      step();
    end
    check("drain_busy_low", 64'(busy), 64'd0);
    drv(1'b0, 4'hF, 1'b0, 32'sd0);
    step();

    // Reset with five in flight; first grant afterwards goes to lowest valid index.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 4'hF, 1'b0, 32'sd0);
      step();
    end
    do_reset();
    drv(1'b1, 4'b1101, 1'b0, 32'sd0);
    step();
    drv(1'b1, 4'b0000, 1'b1, 32'sd77);
    step();
    check("post_reset_chan", 64'(bus.out_chan), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_chan_scheduler.md
FIR_CHAN_SCHEDULER -- requirements
Module: fir_chan_scheduler

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- NCH, 4, number of sample channels sharing one FIR IP instance (power of two, 2..8).
- DEPTH, 16, in-flight tag FIFO depth (power of two).
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high reset.
- enable, in, 1, 1 = grants allowed; 0 = no new grants, in-flight samples still return.
- ch_data, in, NCH*16, signed sample per channel; channel k occupies bits [16k+15:16k].
- ch_valid, in, NCH, per-channel sample valid.
- ch_ready, out, NCH, per-channel accept; at most one bit high per cycle.
- ast_sink_data, out, 16, signed sample to FIR IP sink.
- ast_sink_valid, out, 1, FIR sink valid.
- ast_source_data, in, 32, signed FIR result.
- ast_source_valid, in, 1, FIR result valid; no backpressure available.
- out_data, out, 32, FIR result routed back to a channel.
- out_chan, out, log2(NCH), channel ID of out_data.
- out_valid, out, 1, one-cycle pulse per routed result.
- busy, out, 1, high when tag FIFO count != 0.
- err_orphan, out, 1, sticky; result arrived with no outstanding tag.

Function
REQ-003 ch_ready SHALL be combinational: one-hot on the granted channel when enable=1, tag FIFO count < DEPTH, and at least one ch_valid is high; all-zero otherwise.
REQ-004 Arbitration SHALL be round-robin: search starts at rr_ptr; grant the first channel with ch_valid=1 in order rr_ptr, rr_ptr+1, ... modulo NCH.
REQ-005 On a transfer (ch_valid[g] & ch_ready[g]), rr_ptr SHALL become (g+1) mod NCH on the next edge; otherwise rr_ptr SHALL hold.
REQ-006 A transfer SHALL register ast_sink_data = ch_data[g] and ast_sink_valid = 1 for exactly the next cycle (issue latency 1); ast_sink_valid SHALL be 0 in cycles with no transfer in the previous cycle.
REQ-007 Each transfer SHALL push g into the tag FIFO in the same edge; FIR results are in order, so tags are popped FIFO-order.
REQ-008 On ast_source_valid=1 with count>0, the block SHALL pop one tag and register out_data = ast_source_data, out_chan = popped tag, and out_valid = 1 on the next cycle (return latency 1).
REQ-009 On ast_source_valid=1 with count=0, the block SHALL NOT pop, SHALL keep out_valid = 0, and SHALL set err_orphan = 1 until reset.
REQ-010 A simultaneous push and pop SHALL leave count unchanged; grants SHALL be blocked whenever count = DEPTH, even in a cycle that also pops (conservative full).
REQ-011 The FIFO read and write pointers SHALL wrap modulo DEPTH, with count in the range 0..DEPTH.
REQ-012 Control states SHALL be:
- RUN (enable=1): grants allowed.
- DRAIN (enable=0, count>0): no grants, results still routed.
- IDLE (enable=0, count=0).
Transitions depend only on enable and count, evaluated each cycle.
REQ-013 out_data, out_chan and ast_sink_data SHALL hold their last value when the matching valid is 0.

Reset
REQ-014 While reset=1, the following SHALL be cleared on the clock edge:
- ast_sink_valid, out_valid, err_orphan, busy = 0;
- ast_sink_data, out_data, out_chan = 0;
- rr_ptr = 0 and FIFO count/pointers = 0.
ch_ready SHALL be all-zero during reset.
REQ-015 Reset mid-operation SHALL discard all outstanding tags; the FIR IP SHALL be reset in the same cycles, so no stale results return. A result arriving after reset with no tag SHALL follow REQ-009.

Verification
REQ-016 Single channel: ch_valid=0001, ch_data[0]=8192 for one cycle -> ast_sink_valid=1 with data 8192 next cycle; echo source 0x00010000 -> out_valid=1, out_chan=0, out_data=0x00010000 one cycle later.
REQ-017 All channels valid continuously, rr_ptr=0 -> grant order 0,1,2,3,0,1,... with one grant per cycle; every fourth sink cycle carries channel 0 data.
REQ-018 Full: enable=1, no source results, 16 transfers -> count=16, ch_ready=0000, busy=1; one source result -> out_chan = first granted ID, and a grant resumes the cycle after count drops to 15.
REQ-019 Orphan: after reset, pulse ast_source_valid with data -4096 -> out_valid stays 0, err_orphan=1 and stays 1 until reset.
REQ-020 Drain: 3 in flight, drop enable -> ch_ready=0000 immediately; 3 results route with tags in issue order; busy falls to 0 after the third pop.
REQ-021 Reset mid-run with 5 in flight -> all outputs 0 the next cycle, and the first grant after reset goes to the lowest-index valid channel.
